// File: rtl/ex_stage_pkg.sv
// Shared types and encodings for the execute stage.
// Optional RV32M support is enabled by defining EX_MULDIV_EN.
package ex_stage_pkg;

  localparam int unsigned XLEN_W = 32;
  localparam int unsigned REG_AW = 5;

  // ALUOp encodings coming from the decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  // Operand forwarding selects
  localparam logic [1:0] FWD_IDEX = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  // Opcodes that need special handling in EX
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_LUI, ALU_AUIPC
  } alu_op_e;

  typedef enum logic [1:0] {
    MD_IDLE, MD_BUSY, MD_DONE
  } md_state_e;

  // EX/MEM pipeline register payload
  typedef struct packed {
    logic [XLEN_W-1:0] alu_result;
    logic [XLEN_W-1:0] store_data;
    logic [XLEN_W-1:0] pc_plus4;
    logic [REG_AW-1:0] rd;
    logic [2:0]        funct3;
    logic              mem_read;
    logic              mem_write;
    logic [1:0]        mem2reg;
    logic              reg_write;
  } exmem_t;

endpackage

// File: rtl/ex_stage_muldiv.sv
// Iterative RV32M unit: 32-step shift-add multiply / restoring divide on magnitudes.
module muldiv_unit
  import ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        funct3,
  input  logic [XLEN_W-1:0] op_a,
  input  logic [XLEN_W-1:0] op_b,
  output logic              busy_c,
  output logic              done_c,
  output logic [XLEN_W-1:0] result_c
);

  md_state_e         state_q, state_d;
  logic [63:0]       p_q, p_d;
  logic [31:0]       b_q, b_d;
  logic [31:0]       a_q, a_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic              dz_q, dz_d;

  logic              a_signed, b_signed, sa, sb;
  logic [31:0]       a_mag, b_mag;
  logic [32:0]       mul_sum, div_shift;
  logic              div_ge;
  logic [63:0]       prod_s;

  // Operand signedness and magnitudes at issue
  assign a_signed = ~funct3[0] | (funct3 == 3'b001);
  assign b_signed = (funct3[2] & ~funct3[0]) | (~funct3[2] & ~funct3[1]);
  assign sa       = a_signed & op_a[31];
  assign sb       = b_signed & op_b[31];
  assign a_mag    = sa ? 32'(32'd0 - op_a) : op_a;
  assign b_mag    = sb ? 32'(32'd0 - op_b) : op_b;

  // One iteration of each algorithm
  assign mul_sum   = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, b_q} : 33'd0);
  assign div_shift = {p_q[63:32], p_q[31]};
  assign div_ge    = div_shift >= {1'b0, b_q};

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      p_q     <= '0;
      b_q     <= '0;
      a_q     <= '0;
      cnt_q   <= '0;
      f3_q    <= '0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      b_q     <= b_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      neg_q   <= neg_d;
      dz_q    <= dz_d;
    end
  end

  // Next-state, iteration step and stall
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    b_d     = b_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          busy_c  = 1'b1;
          state_d = MD_BUSY;
          cnt_d   = '0;
          p_d     = {32'd0, a_mag};
          b_d     = b_mag;
          a_d     = op_a;
          f3_d    = funct3;
          neg_d   = (funct3[2] & funct3[1]) ? sa : (sa ^ sb);
          dz_d    = (op_b == 32'd0);
        end
      end
      MD_BUSY: begin
        busy_c = 1'b1;
        cnt_d  = cnt_q + 5'd1;
        if (f3_q[2]) begin
          if (div_ge) p_d = {32'(div_shift - {1'b0, b_q}), p_q[30:0], 1'b1};
          else        p_d = {div_shift[31:0], p_q[30:0], 1'b0};
        end else begin
          p_d = {mul_sum, p_q[31:1]};
        end
        if (cnt_q == 5'd31) state_d = MD_DONE;
      end
      MD_DONE: begin
        done_c  = 1'b1;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // Sign fix-up and special cases on the final value
  assign prod_s = neg_q ? (64'd0 - p_q) : p_q;

  always_comb begin
    result_c = '0;
    case (f3_q)
      3'b000:                 result_c = prod_s[31:0];
      3'b001, 3'b010, 3'b011: result_c = prod_s[63:32];
      3'b100, 3'b101:         result_c = dz_q ? 32'hFFFF_FFFF : prod_s[31:0];
      default:                result_c = dz_q ? a_q
                                       : (neg_q ? 32'(32'd0 - p_q[63:32]) : p_q[63:32]);
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarding, ALU, branch resolve and the EX/MEM register.
// Define EX_MULDIV_EN to add the iterative RV32M unit.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] read_data1_IDEX,
  input  logic [XLEN-1:0] read_data2_IDEX,
  input  logic [XLEN-1:0] PC_IDEX,
  input  logic [XLEN-1:0] PC_plus4_IDEX,
  input  logic [XLEN-1:0] imm_IDEX,
  input  logic [31:0]     instruc_IDEX,
  input  logic [4:0]      rd_IDEX,
  input  logic            branch_IDEX,
  input  logic            memRead_IDEX,
  input  logic [1:0]      mem2reg_IDEX,
  input  logic            memWrite_IDEX,
  input  logic            ALUSrc_IDEX,
  input  logic            RegWrite_IDEX,
  input  logic            jump_IDEX,
  input  logic [1:0]      ALUOp_IDEX,
  input  logic [1:0]      forwardA,
  input  logic [1:0]      forwardB,
  input  logic [XLEN-1:0] write_Data,
  output logic [XLEN-1:0] alu_result_EXMEM,
  output logic [XLEN-1:0] store_data_EXMEM,
  output logic [XLEN-1:0] PC_plus4_EXMEM,
  output logic [4:0]      rd_EXMEM,
  output logic [2:0]      funct3_EXMEM,
  output logic            memRead_EXMEM,
  output logic            memWrite_EXMEM,
  output logic [1:0]      mem2reg_EXMEM,
  output logic            RegWrite_EXMEM,
  output logic [XLEN-1:0] pc_target,
  output logic            pc_sel,
  output logic            flush_IF,
  output logic            flush_ID,
  output logic            stall_EX
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            m_op;
  logic [XLEN-1:0] op_a, fwd_b, op_b, alu_res, ex_res, jalr_sum;
  alu_op_e         alu_op;
  logic            taken;
  exmem_t          exmem_q, exmem_d;
  logic            unused_bits;

  assign opcode = instruc_IDEX[6:0];
  assign funct3 = instruc_IDEX[14:12];
  assign funct7 = instruc_IDEX[31:25];
  assign m_op   = (ALUOp_IDEX == ALUOP_RTYPE) && (funct7 == F7_MULDIV);

  // Forwarding muxes; the reserved select falls back to the ID/EX value
  always_comb begin
    op_a  = read_data1_IDEX;
    fwd_b = read_data2_IDEX;
    case (forwardA)
      FWD_IDEX: op_a = read_data1_IDEX;
      FWD_WB:   op_a = write_Data;
      FWD_MEM:  op_a = alu_result_EXMEM;
      default:  op_a = read_data1_IDEX;
    endcase
    case (forwardB)
      FWD_IDEX: fwd_b = read_data2_IDEX;
      FWD_WB:   fwd_b = write_Data;
      FWD_MEM:  fwd_b = alu_result_EXMEM;
      default:  fwd_b = read_data2_IDEX;
    endcase
  end

  assign op_b = ALUSrc_IDEX ? imm_IDEX : fwd_b;

  // ALU operation decode; funct7[5] only matters for SUB and SRA/SRAI
  always_comb begin
    alu_op = ALU_ADD;
    case (ALUOp_IDEX)
      ALUOP_ADD: alu_op = ALU_ADD;
      ALUOP_SUB: alu_op = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  alu_op = (ALUOp_IDEX == ALUOP_RTYPE && funct7[5]) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_op = ALU_SLL;
          3'b010:  alu_op = ALU_SLT;
          3'b011:  alu_op = ALU_SLTU;
          3'b100:  alu_op = ALU_XOR;
          3'b101:  alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
    endcase
    if (opcode == OPC_LUI)   alu_op = ALU_LUI;
    if (opcode == OPC_AUIPC) alu_op = ALU_AUIPC;
  end

  // ALU datapath
  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD:   alu_res = op_a + op_b;
      ALU_SUB:   alu_res = op_a - op_b;
      ALU_SLL:   alu_res = op_a << op_b[4:0];
      ALU_SLT:   alu_res = XLEN'($signed(op_a) < $signed(op_b));
      ALU_SLTU:  alu_res = XLEN'(op_a < op_b);
      ALU_XOR:   alu_res = op_a ^ op_b;
      ALU_SRL:   alu_res = op_a >> op_b[4:0];
      ALU_SRA:   alu_res = XLEN'($signed(op_a) >>> op_b[4:0]);
      ALU_OR:    alu_res = op_a | op_b;
      ALU_AND:   alu_res = op_a & op_b;
      ALU_LUI:   alu_res = imm_IDEX;
      ALU_AUIPC: alu_res = PC_IDEX + imm_IDEX;
      default:   alu_res = '0;
    endcase
  end

  // Branch condition on forwarded rs1/rs2
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = (op_a == fwd_b);
      3'b001:  taken = (op_a != fwd_b);
      3'b100:  taken = ($signed(op_a) <  $signed(fwd_b));
      3'b101:  taken = ($signed(op_a) >= $signed(fwd_b));
      3'b110:  taken = (op_a <  fwd_b);
      3'b111:  taken = (op_a >= fwd_b);
      default: taken = 1'b0;
    endcase
  end

  assign jalr_sum  = op_a + imm_IDEX;
  assign pc_target = (opcode == OPC_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : (PC_IDEX + imm_IDEX);

`ifdef EX_MULDIV_EN
  logic            md_busy_c, md_done_c;
  logic [XLEN-1:0] md_result_c;

  muldiv_unit u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (m_op),
    .funct3   (funct3),
    .op_a     (op_a),
    .op_b     (fwd_b),
    .busy_c   (md_busy_c),
    .done_c   (md_done_c),
    .result_c (md_result_c)
  );

  assign stall_EX    = rst_n & md_busy_c;
  assign unused_bits = ^{instruc_IDEX, md_done_c};
`else
  assign stall_EX    = 1'b0;
  assign unused_bits = ^{instruc_IDEX, m_op};
`endif

  assign pc_sel   = rst_n & (jump_IDEX | (branch_IDEX & taken)) & ~stall_EX;
  assign flush_IF = pc_sel;
  assign flush_ID = pc_sel;

  // Value written back: link address for jumps, M-unit result when done
  always_comb begin
    ex_res = alu_res;
    if (jump_IDEX) ex_res = PC_plus4_IDEX;
`ifdef EX_MULDIV_EN
    if (m_op)      ex_res = md_result_c;
`endif
  end

  // EX/MEM next value; a stall inserts a bubble
  always_comb begin
    exmem_d = '0;
    if (!stall_EX) begin
      exmem_d.alu_result = ex_res;
      exmem_d.store_data = fwd_b;
      exmem_d.pc_plus4   = PC_plus4_IDEX;
      exmem_d.rd         = rd_IDEX;
      exmem_d.funct3     = funct3;
      exmem_d.mem_read   = memRead_IDEX;
      exmem_d.mem_write  = memWrite_IDEX;
      exmem_d.mem2reg    = mem2reg_IDEX;
      exmem_d.reg_write  = RegWrite_IDEX;
    end
  end

  // EX/MEM pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) exmem_q <= '0;
    else        exmem_q <= exmem_d;
  end

  assign alu_result_EXMEM = exmem_q.alu_result;
  assign store_data_EXMEM = exmem_q.store_data;
  assign PC_plus4_EXMEM   = exmem_q.pc_plus4;
  assign rd_EXMEM         = exmem_q.rd;
  assign funct3_EXMEM     = exmem_q.funct3;
  assign memRead_EXMEM    = exmem_q.mem_read;
  assign memWrite_EXMEM   = exmem_q.mem_write;
  assign mem2reg_EXMEM    = exmem_q.mem2reg;
  assign RegWrite_EXMEM   = exmem_q.reg_write;

endmodule
